// File: rtl/sorter_cmd_rx.sv
// sorter_cmd_rx: UART command receiver, 4-entry command FIFO and hold-off spaced strobe issue; define CMD_LOWER_EN to also accept lowercase commands
module sorter_cmd_rx #(
    parameter int BAUD_DIV = 5208,
    parameter int HOLD_POS = 52000000,
    parameter int HOLD_GO  = 101000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       go,
    output logic       posRed,
    output logic       posGreen,
    output logic       posBlue,
    output logic       busy,
    output logic [2:0] fifo_count,
    output logic       frame_err,
    output logic       ovf,
    output logic       bad_cmd
);
    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
    localparam logic [26:0]   HP        = 27'(HOLD_POS);
    localparam logic [26:0]   HG        = 27'(HOLD_GO);

    typedef enum logic [2:0] {R_WAIT_IDLE, R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {I_IDLE, I_ISSUE, I_HOLD} iss_state_t;

    rx_state_t  rs;
    iss_state_t is;
    logic          rx_m, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_byte, cmd_byte;
    logic          byte_valid, cmd_ok, pop, push_acc;
    logic [1:0]    cmd_code, cur_code, wr_ptr, rd_ptr, head;
    logic [1:0]    mem [4];
    logic [26:0]   hold_cnt;

`ifdef CMD_LOWER_EN
    assign cmd_byte = rx_byte & 8'hDF;
`else
    assign cmd_byte = rx_byte;
`endif
    assign head     = mem[rd_ptr];
    assign pop      = (is == I_IDLE) && (fifo_count != 3'd0);
    assign push_acc = byte_valid && cmd_ok && (fifo_count != 3'd4 || pop);
    assign busy     = is != I_IDLE;

    // map a received byte onto a 2-bit command code
    always_comb begin
        cmd_ok   = cmd_byte inside {8'h44, 8'h52, 8'h47, 8'h42};
        cmd_code = cmd_byte == 8'h52 ? 2'd1 : cmd_byte == 8'h47 ? 2'd2 : cmd_byte == 8'h42 ? 2'd3 : 2'd0;
    end

    // two-flop synchronizer for the asynchronous serial line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b0;
            rx_s <= 1'b0;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // 8N1 receiver sampling mid-bit, with glitch rejection on the start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs         <= R_WAIT_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rs)
                R_WAIT_IDLE: if (rx_s) rs <= R_IDLE;
                R_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rx_s) rs <= R_START;
                end
                R_START: if (cnt == HALF_LAST) begin
                    cnt <= '0;
                    rs  <= rx_s ? R_IDLE : R_DATA;
                end else cnt <= cnt + 1'b1;
                R_DATA: if (cnt == BIT_LAST) begin
                    cnt     <= '0;
                    rx_byte <= {rx_s, rx_byte[7:1]};
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == 3'd7) rs <= R_STOP;
                end else cnt <= cnt + 1'b1;
                R_STOP: if (cnt == BIT_LAST) begin
                    cnt        <= '0;
                    byte_valid <= rx_s;
                    frame_err  <= !rx_s;
                    rs         <= rx_s ? R_IDLE : R_WAIT_IDLE;
                end else cnt <= cnt + 1'b1;
                default: rs <= R_WAIT_IDLE;
            endcase
        end
    end

    // command FIFO with overflow and bad-command flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem        <= '{default: 2'd0};
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ovf        <= 1'b0;
            bad_cmd    <= 1'b0;
        end else begin
            ovf        <= byte_valid && cmd_ok && !push_acc;
            bad_cmd    <= byte_valid && !cmd_ok;
            fifo_count <= fifo_count + 3'(push_acc) - 3'(pop);
            if (push_acc) begin
                mem[wr_ptr] <= cmd_code;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // issue FSM: pop, strobe for one cycle, then hold off for the servo sequence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is       <= I_IDLE;
            hold_cnt <= '0;
            cur_code <= '0;
            go       <= 1'b0;
            posRed   <= 1'b0;
            posGreen <= 1'b0;
            posBlue  <= 1'b0;
        end else begin
            go       <= 1'b0;
            posRed   <= 1'b0;
            posGreen <= 1'b0;
            posBlue  <= 1'b0;
            case (is)
                I_IDLE: if (pop) begin
                    cur_code <= head;
                    go       <= head == 2'd0;
                    posRed   <= head == 2'd1;
                    posGreen <= head == 2'd2;
                    posBlue  <= head == 2'd3;
                    is       <= I_ISSUE;
                end
                I_ISSUE: begin
                    hold_cnt <= cur_code == 2'd0 ? HG : HP;
                    is       <= I_HOLD;
                end
                I_HOLD: begin
                    hold_cnt <= hold_cnt - 1'b1;
                    if (hold_cnt == 27'd1) is <= I_IDLE;
                end
                default: is <= I_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sorter_cmd_rx.sv
// tb_sorter_cmd_rx: randomized bench for sorter_cmd_rx against an event-level model, two hold-off configurations
module tb_sorter_cmd_rx;
    localparam int B = 16;
    localparam int LAT = 3;
    localparam int HOLD_P [2] = '{40, 40};
    localparam int HOLD_G [2] = '{80, 1200};

    logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
    logic [1:0] go_v, red_v, grn_v, blu_v, busy_v, ferr_v, ovf_v, bad_v;
    logic [2:0] cnt_v [2];
    int cyc = 0;
    int tests = 0, fails = 0;

    int acc_push [2][$];
    int acc_strobe [2][$];
    int exp_ev [2][$];
    int obs_ev [2][$];
    int last_t [2], last_h [2], exp_busy [2], exp_peak [2], exp_done [2];
    int obs_busy [2], obs_peak [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sorter_cmd_rx #(.BAUD_DIV(B), .HOLD_POS(40), .HOLD_GO(80)) u_dut (
        .clk(clk), .rst(rst), .rx(rx), .go(go_v[0]), .posRed(red_v[0]), .posGreen(grn_v[0]),
        .posBlue(blu_v[0]), .busy(busy_v[0]), .fifo_count(cnt_v[0]), .frame_err(ferr_v[0]),
        .ovf(ovf_v[0]), .bad_cmd(bad_v[0]));

    sorter_cmd_rx #(.BAUD_DIV(B), .HOLD_POS(40), .HOLD_GO(1200)) u_big (
        .clk(clk), .rst(rst), .rx(rx), .go(go_v[1]), .posRed(red_v[1]), .posGreen(grn_v[1]),
        .posBlue(blu_v[1]), .busy(busy_v[1]), .fifo_count(cnt_v[1]), .frame_err(ferr_v[1]),
        .ovf(ovf_v[1]), .bad_cmd(bad_v[1]));

    // event key = cycle*8 + kind; kinds 0..3 strobe code, 4 frame_err, 5 bad_cmd, 6 ovf
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (go_v[i])   obs_ev[i].push_back(cyc * 8 + 0);
                if (red_v[i])  obs_ev[i].push_back(cyc * 8 + 1);
                if (grn_v[i])  obs_ev[i].push_back(cyc * 8 + 2);
                if (blu_v[i])  obs_ev[i].push_back(cyc * 8 + 3);
                if (ferr_v[i]) obs_ev[i].push_back(cyc * 8 + 4);
                if (bad_v[i])  obs_ev[i].push_back(cyc * 8 + 5);
                if (ovf_v[i])  obs_ev[i].push_back(cyc * 8 + 6);
                if (busy_v[i]) obs_busy[i]++;
                if (int'(cnt_v[i]) > obs_peak[i]) obs_peak[i] = int'(cnt_v[i]);
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int outs(int i);
        return int'({go_v[i], red_v[i], grn_v[i], blu_v[i], busy_v[i], cnt_v[i], ferr_v[i], ovf_v[i], bad_v[i]});
    endfunction

    function automatic void clear_phase();
        for (int i = 0; i < 2; i++) begin
            acc_push[i].delete();
            acc_strobe[i].delete();
            exp_ev[i].delete();
            obs_ev[i].delete();
            last_t[i]   = -100000;
            last_h[i]   = 0;
            exp_busy[i] = 0;
            exp_peak[i] = 0;
            exp_done[i] = 0;
            obs_busy[i] = 0;
            obs_peak[i] = 0;
        end
    endfunction

    // frame whose start bit is driven right after edge c: stop bit sampled at edge s
    function automatic void model_frame(int c, logic [7:0] b, logic stop);
        int s, t, occ, tt, h, code;
        bit pop_now;
        s = c + LAT + B / 2 + 9 * B;
        t = s + 1;
        case (b)
            8'h44: code = 0;
            8'h52: code = 1;
            8'h47: code = 2;
            8'h42: code = 3;
`ifdef CMD_LOWER_EN
            8'h64: code = 0;
            8'h72: code = 1;
            8'h67: code = 2;
            8'h62: code = 3;
`endif
            default: code = -1;
        endcase
        for (int i = 0; i < 2; i++) begin
            if (!stop) exp_ev[i].push_back(s * 8 + 4);
            else if (code < 0) exp_ev[i].push_back(t * 8 + 5);
            else begin
                occ = 0;
                pop_now = 0;
                foreach (acc_push[i][j]) begin
                    if (acc_push[i][j] < t && acc_strobe[i][j] >= t) occ++;
                    if (acc_strobe[i][j] == t) pop_now = 1;
                end
                if (occ == 4 && !pop_now) exp_ev[i].push_back(t * 8 + 6);
                else begin
                    h  = code == 0 ? HOLD_G[i] : HOLD_P[i];
                    tt = last_t[i] + last_h[i] + 2 > t + 1 ? last_t[i] + last_h[i] + 2 : t + 1;
                    acc_push[i].push_back(t);
                    acc_strobe[i].push_back(tt);
                    exp_ev[i].push_back(tt * 8 + code);
                    exp_busy[i] += h + 1;
                    if (occ + 1 - int'(pop_now) > exp_peak[i]) exp_peak[i] = occ + 1 - int'(pop_now);
                    exp_done[i] = tt + h + 2;
                    last_t[i] = tt;
                    last_h[i] = h;
                end
            end
        end
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        @(posedge clk);
        #1;
        model_frame(cyc, b, stop);
        for (int k = 0; k < 10; k++) begin
            rx = f[k];
            repeat (B) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic end_phase(input string tag);
        int w, n;
        int e[$], o[$];
        w = cyc + 4;
        for (int i = 0; i < 2; i++) if (exp_done[i] > w) w = exp_done[i];
        while (cyc < w) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            e = exp_ev[i];
            o = obs_ev[i];
            e.sort();
            o.sort();
            check($sformatf("%s_u%0d_events", tag, i), o.size(), e.size());
            n = o.size() < e.size() ? o.size() : e.size();
            for (int j = 0; j < n; j++) check($sformatf("%s_u%0d_ev%0d", tag, i, j), o[j], e[j]);
            check($sformatf("%s_u%0d_busy", tag, i), obs_busy[i], exp_busy[i]);
            check($sformatf("%s_u%0d_peak", tag, i), obs_peak[i], exp_peak[i]);
        end
    endtask

    initial begin
        logic [7:0] b;
        logic stop;
        clear_phase();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) check($sformatf("reset_u%0d_outs", i), outs(i), 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        clear_phase();
        send_frame(8'h52, 1'b1);
        end_phase("single");

        clear_phase();
        send_frame(8'h47, 1'b1);
        send_frame(8'h44, 1'b1);
        send_frame(8'h42, 1'b1);
        end_phase("ordered");

        clear_phase();
        send_frame(8'h44, 1'b1);
        repeat (5) send_frame(8'h52, 1'b1);
        end_phase("overflow");
        check("overflow_u1_peak_full", obs_peak[1], 4);

        clear_phase();
        send_frame(8'h52, 1'b0);
        repeat (24) @(posedge clk);
        send_frame(8'h58, 1'b1);
        send_frame(8'h72, 1'b1);
        end_phase("errors");

        clear_phase();
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (40) @(posedge clk);
        end_phase("glitch");

        clear_phase();
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 7))
                0: b = 8'h44;
                1: b = 8'h52;
                2: b = 8'h47;
                3: b = 8'h42;
                4: b = 8'h58;
                5: b = 8'h72;
                6: b = 8'h64;
                default: b = 8'($urandom);
            endcase
            stop = $urandom_range(0, 7) != 0;
            send_frame(b, stop);
            repeat ($urandom_range(0, 30) + (stop ? 0 : 24)) @(posedge clk);
        end
        end_phase("random");

        clear_phase();
        send_frame(8'h44, 1'b1);
        send_frame(8'h52, 1'b1);
        send_frame(8'h47, 1'b1);
        check("midhold_u1_queued", int'(cnt_v[1]), 2);
        check("midhold_u1_busy", int'(busy_v[1]), 1);
        rst = 1'b1;
        rx  = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) check($sformatf("midhold_u%0d_outs", i), outs(i), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1 rx = 1'b1;
        repeat (10) @(posedge clk);
        clear_phase();
        send_frame(8'h42, 1'b1);
        end_phase("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
